// File: rtl/tic_tac_toe_pkg.sv
// -----------------------------------------------------------------------------
// tic_tac_toe_pkg
// Shared board geometry and types for the tic-tac-toe judge.
//   cell_t   : 2-bit cell code (00 empty, 01 mark A, 10 mark B, 11 invalid)
//   state_t  : judge sequencer states
//   N_CELLS  : 9 cells, row-major, 0 = top-left, 8 = bottom-right
//   N_LINES  : 8 winning lines
//   LINES    : cell indices of each line; rows, then columns, then diagonals
// -----------------------------------------------------------------------------
package tic_tac_toe_pkg;

  localparam int N_CELLS = 9;
  localparam int N_LINES = 8;

  // INVALID is named so a corrupt 11 read from the board is a legal value
  // of the type; it never matches a player and counts as an empty cell.
  typedef enum logic [1:0] {
    EMPTY   = 2'b00,
    MARK_A  = 2'b01,
    MARK_B  = 2'b10,
    INVALID = 2'b11
  } cell_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_CAPTURE,
    ST_EVAL,
    ST_DONE
  } state_t;

  localparam logic [3:0] LINES [N_LINES][3] = '{
    '{4'd0, 4'd1, 4'd2},
    '{4'd3, 4'd4, 4'd5},
    '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8},
    '{4'd2, 4'd4, 4'd6}
  };

endpackage

// File: rtl/board_line_check.sv
// -----------------------------------------------------------------------------
// board_line_check
// Combinational test of one three-cell line.
//   i_cell0..2 : the three cells of the line
//   line_a     : all three cells hold mark A
//   line_b     : all three cells hold mark B
// -----------------------------------------------------------------------------
module board_line_check
  import tic_tac_toe_pkg::*;
(
  input  cell_t i_cell0,
  input  cell_t i_cell1,
  input  cell_t i_cell2,
  output logic  line_a,
  output logic  line_b
);

  assign line_a = (i_cell0 == MARK_A) && (i_cell1 == MARK_A) && (i_cell2 == MARK_A);
  assign line_b = (i_cell0 == MARK_B) && (i_cell1 == MARK_B) && (i_cell2 == MARK_B);

endmodule

// File: rtl/board_judge.sv
// -----------------------------------------------------------------------------
// board_judge
// On request, reads the 9 board cells into a snapshot, checks the 8 lines one
// per cycle and publishes win / game-over flags.
//   clk              : clock, rising edge
//   reset            : asynchronous active-high reset
//   make_judge_req   : one-cycle judge request
//   make_judge_ready : idle and results valid (low while req is high)
//   board_rd         : board read strobe
//   board_addr       : cell index being read, 0..8
//   board_q          : cell contents, valid the cycle after board_rd
//   end_of_game      : win for either player or no empty cell left
//   win_a / win_b    : player owns a complete line (both may be set)
// -----------------------------------------------------------------------------
module board_judge
  import tic_tac_toe_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       make_judge_req,
  output logic       make_judge_ready,
  output logic       board_rd,
  output logic [3:0] board_addr,
  input  logic [1:0] board_q,
  output logic       end_of_game,
  output logic       win_a,
  output logic       win_b
);

  state_t     r_state;
  state_t     w_state_next;
  logic       r_ready_q;
  logic       r_rd;
  logic [3:0] r_addr;
  logic       r_cap_en;     // board_q carries the cell addressed last cycle
  logic [3:0] r_cap_idx;
  cell_t      r_snap [N_CELLS];
  logic [2:0] r_line;
  logic       r_acc_a;
  logic       r_acc_b;
  logic       r_eog;
  logic       r_win_a;
  logic       r_win_b;

  logic       w_accept;
  logic       w_fetch_last;
  logic       w_last_line;
  logic       w_line_a;
  logic       w_line_b;
  logic       w_full;

  assign w_accept     = (r_state == ST_IDLE) && r_ready_q && make_judge_req;
  assign w_fetch_last = (r_state == ST_FETCH) && (r_addr == 4'(N_CELLS - 1));
  assign w_last_line  = (r_state == ST_EVAL) && (r_line == 3'(N_LINES - 1));

  assign make_judge_ready = r_ready_q & ~make_judge_req;
  assign board_rd         = r_rd;
  assign board_addr       = r_addr;
  assign end_of_game      = r_eog;
  assign win_a            = r_win_a;
  assign win_b            = r_win_b;

  board_line_check u_line_check (
    .i_cell0 (r_snap[LINES[r_line][0]]),
    .i_cell1 (r_snap[LINES[r_line][1]]),
    .i_cell2 (r_snap[LINES[r_line][2]]),
    .line_a  (w_line_a),
    .line_b  (w_line_b)
  );

  // 11 is treated as empty, so only fully A/B-marked boards are full.
  always_comb begin
    w_full = 1'b1;
    for (int i = 0; i < N_CELLS; i++) begin
      if (r_snap[i] == EMPTY || r_snap[i] == INVALID) begin
        w_full = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_accept) w_state_next = ST_FETCH;
      ST_FETCH:   if (w_fetch_last) w_state_next = ST_CAPTURE;
      ST_CAPTURE: w_state_next = ST_EVAL;
      ST_EVAL:    if (w_last_line) w_state_next = ST_DONE;
      ST_DONE:    w_state_next = ST_IDLE;
      default:    w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ready_q <= 1'b1;
      r_rd      <= 1'b0;
      r_addr    <= 4'd0;
      r_cap_en  <= 1'b0;
      r_cap_idx <= 4'd0;
      r_line    <= 3'd0;
      r_acc_a   <= 1'b0;
      r_acc_b   <= 1'b0;
      r_eog     <= 1'b0;
      r_win_a   <= 1'b0;
      r_win_b   <= 1'b0;
      for (int i = 0; i < N_CELLS; i++) begin
        r_snap[i] <= EMPTY;
      end
    end else begin
      // Capture is keyed off the delayed strobe, so board_q is ignored in
      // every cycle that does not follow a read.
      r_cap_en  <= r_rd;
      r_cap_idx <= r_addr;
      if (r_cap_en) begin
        r_snap[r_cap_idx] <= cell_t'(board_q);
      end

      if (w_accept) begin
        r_ready_q <= 1'b0;
        r_rd      <= 1'b1;
        r_addr    <= 4'd0;
      end else if (r_state == ST_FETCH) begin
        if (w_fetch_last) begin
          r_rd   <= 1'b0;
          r_addr <= 4'd0;
        end else begin
          r_addr <= r_addr + 4'd1;
        end
      end

      if (r_state == ST_CAPTURE) begin
        r_line  <= 3'd0;
        r_acc_a <= 1'b0;
        r_acc_b <= 1'b0;
      end else if (r_state == ST_EVAL) begin
        r_line  <= r_line + 3'd1;
        r_acc_a <= r_acc_a | w_line_a;
        r_acc_b <= r_acc_b | w_line_b;
        // Results are published only together with the rise of ready.
        if (w_last_line) begin
          r_ready_q <= 1'b1;
          r_win_a   <= r_acc_a | w_line_a;
          r_win_b   <= r_acc_b | w_line_b;
          r_eog     <= r_acc_a | w_line_a | r_acc_b | w_line_b | w_full;
        end
      end
    end
  end

endmodule

// File: doc/board_judge.md
BOARD_JUDGE -- requirements
Module: board_judge

Interface
REQ-001 Parameters: none; board geometry (3x3, 8 lines) SHALL come from the shared package.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-high.
REQ-004 make_judge_req  input  1  one-cycle judge request from the game controller.
REQ-005 make_judge_ready  output  1  high = idle, results valid, request accepted.
REQ-006 board_rd  output  1  board read strobe.
REQ-007 board_addr  output  4  cell index 0..8, row-major (0 top-left, 8 bottom-right).
REQ-008 board_q  input  2  cell contents, valid the cycle after board_rd: 00 empty, 01 mark A, 10 mark B, 11 treated as empty.
REQ-009 end_of_game  output  1  game over (win or full board).
REQ-010 win_a  output  1  A owns a complete line.
REQ-011 win_b  output  1  B owns a complete line.

Function
REQ-012 States: IDLE, FETCH, CAPTURE, EVAL, DONE; DONE returns to IDLE after one cycle.
REQ-013 make_judge_ready SHALL equal registered ready_q AND NOT make_judge_req, so ready is low in the cycle req is high.
REQ-014 A request SHALL be accepted only in IDLE with ready_q=1; ready_q clears on acceptance.
REQ-015 A request in any other state SHALL be ignored and not queued.
REQ-016 FETCH: board_rd=1 for exactly 9 consecutive cycles, board_addr 0..8 ascending, starting the cycle after acceptance.
REQ-017 board_rd SHALL be 0 in every other state.
REQ-018 board_q for address k SHALL be captured one cycle after k is driven into a 9-cell snapshot; the last capture happens in CAPTURE.
REQ-019 EVAL SHALL check one line per cycle, index 0..7 in package order: rows, then columns, then diagonals 0-4-8 and 2-4-6.
REQ-020 A line SHALL count for a player only if all 3 cells equal that player's code; 11 never matches.
REQ-021 win_a / win_b SHALL be the OR over all 8 lines; both SHALL be reported if both hold (corrupt board, no arbitration).
REQ-022 end_of_game = win_a OR win_b OR no snapshot cell empty (00 or 11).
REQ-023 Latency: request sampled high in cycle T gives ready_q=1 and new results in cycle T+19 (9 FETCH, 1 CAPTURE, 8 EVAL, 1 DONE).
REQ-024 end_of_game, win_a and win_b SHALL update only on the edge where ready_q rises.
REQ-025 Those outputs SHALL hold their previous values while busy and stay stable until the next completion.
REQ-026 board_q SHALL be ignored outside the capture cycles.

Reset
REQ-027 On reset assertion, independent of clk: state=IDLE, ready_q=1, board_rd=0, board_addr=0, end_of_game=0, win_a=0, win_b=0, snapshot and line counter cleared.
REQ-028 A reset mid-scan SHALL abort the scan with no partial result visible.
REQ-029 The first request after reset deassertion SHALL be accepted normally.

Structure
REQ-030 The shared package tic_tac_toe_pkg SHALL hold cell_t (EMPTY=00, MARK_A=01, MARK_B=10), N_CELLS=9, N_LINES=8, and the constant LINES table (8 x 3 cell indices).
REQ-031 A combinational sub-module board_line_check SHALL take 3 cell_t values and output line_a and line_b.
REQ-032 One instance of board_line_check SHALL be used, indexed by the EVAL counter.

Verification
REQ-033 Reset, empty board, req at T: ready low at T, board_addr 0..8 in T+1..T+9, ready=1 at T+19 with end_of_game=0, win_a=0, win_b=0.
REQ-034 A on cells 0,4,8 and B on 1,2, others empty: win_a=1, win_b=0, end_of_game=1.
REQ-035 Full draw A B A / A B B / B A A: end_of_game=1, win_a=0, win_b=0.
REQ-036 B on 2,5,8, cell 0=11, others empty: win_b=1, win_a=0, end_of_game=1; same board without B column: end_of_game=0.
REQ-037 Reset pulsed at T+5 of a scan: outputs at reset values immediately, ready=1; a following req completes at +19 with correct results.
REQ-038 Extra req pulses at T+3 and T+12: ignored, exactly 9 reads, single completion at T+19, results unchanged before it.
